dff_write_arbiter: RTL and testbench
====================================

Name: dff_write_arbiter

Overview:
- Shares one W-bit D-flip-flop holding register between N requesters.
- Each requester raises REQ with its data; the block picks one round-robin, clocks that data into the shared register Q on the next edge, and pulses ACK back.
- Sits in front of any shared register/DFF bank in the datapath that several masters write.

Parameters:
- N, 4, number of requesters (2..8)
- W, 8, data width of shared register
- PW, $clog2(N), width of grant index

Ports:
- CK  input  1  clock, all state on rising edge
- RST  input  1  synchronous reset, active-high, sampled on rising CK
- REQ  input  N  per-requester write request, level, held until ACK
- DIN  input  N*W  requester data, requester i at DIN[i*W +: W]
- ACK  output  N  one-hot, one-cycle pulse: requester's write completed
- GNT_VLD  output  1  a grant is outstanding (SAMPLE state)
- GNT_ID  output  PW  index of current/last granted requester
- Q  output  W  shared register contents
- BUSY  output  1  high in any state other than IDLE

Behaviour:
- Reset (RST=1 at rising CK) overrides everything, including mid-transaction:
  - Q=0, ACK=0, GNT_VLD=0, GNT_ID=0, BUSY=0
  - round-robin pointer PTR=0, state=IDLE
- States: IDLE, SAMPLE. All outputs are registered.
- IDLE:
  - Eligible set E = REQ & ~ACK. The just-acked requester is masked for one cycle.
  - E==0: stay in IDLE.
  - E!=0: winner = first set bit of E searching PTR, PTR+1, ..., wrapping mod N.
  - On the next edge: GNT_ID<=winner, GNT_VLD<=1, BUSY<=1, state<=SAMPLE.
- SAMPLE:
  - REQ[GNT_ID]==1 on the edge: Q<=DIN[GNT_ID*W +: W], ACK<=one-hot(GNT_ID), PTR<=(GNT_ID+1) mod N, GNT_VLD<=0, state<=IDLE.
  - REQ[GNT_ID]==0 (abort): Q unchanged, ACK=0, PTR unchanged, GNT_VLD<=0, state<=IDLE.
  - Data is sampled in SAMPLE, not IDLE. A requester may change DIN until the SAMPLE edge.
- Latency and throughput:
  - Q updates 2 edges after REQ is first seen in IDLE.
  - ACK is high in the same cycle that Q first shows the new value.
  - Maximum throughput is one write per 2 cycles.
- ACK is exactly one cycle wide and never has more than one bit set. ACK is cleared on every edge it is not set.
- Requester protocol: drop REQ on the edge after seeing ACK, or keep it high to re-request. A kept-high request is eligible again from the cycle after ACK.
- REQ changes of non-granted requesters during SAMPLE do not affect the current grant.
- Pointer wrap: grant to N-1 sets PTR=0.
- All requesters continuously requesting: grants cycle 0,1,...,N-1,0,... with no requester granted twice before all others are granted once.
- GNT_ID holds its last value while GNT_VLD=0.

Optional Feature:
- Macro: DFF_ARB_PRIO0_EN
- Defined:
  - Requester 0 has absolute priority. If E[0]=1 in IDLE, the winner is 0 regardless of PTR.
  - A grant to 0 does not advance PTR.
  - Other requesters arbitrate round-robin as above.
- Undefined: pure round-robin as specified; requester 0 has no special treatment.

Decomposition:
- Package dff_arb_pkg:
  - state enum (IDLE, SAMPLE)
  - default N and W constants
  - function for one-hot of an index
- Sub-module dff_arb_rr_pick:
  - combinational; inputs E[N] and PTR[PW], outputs winner[PW] and any.
  - The DFF_ARB_PRIO0_EN override lives in the parent, not the picker.

Test Plan:
- Reset: apply RST for 2 cycles mid-SAMPLE with REQ=4'b0010 -> Q=0, ACK=0, GNT_VLD=0, BUSY=0, and the next grant goes to 1 with PTR restarting at 0.
- Single requester: REQ=4'b0100, DIN[2]=8'hA5 -> GNT_ID=2 after 1 edge; Q=8'hA5 and ACK=4'b0100 after 2 edges; PTR=3.
- Full contention: REQ=4'b1111 held, DIN[i]=8'h10+i -> Q sequence 10,11,12,13,10 on every second cycle; ACK one-hot follows 0001,0010,0100,1000.
- Wrap: PTR=3 after granting 2, then REQ=4'b1001 -> grant 3, then 0; Q takes DIN[3] then DIN[0].
- Abort: REQ=4'b0001 for 1 cycle only -> SAMPLE sees REQ[0]=0; Q unchanged, no ACK, PTR unchanged, return to IDLE.
- With DFF_ARB_PRIO0_EN: REQ=4'b1110 while PTR=1, then REQ[0] rises -> 0 wins at the next IDLE even though PTR points at 2.

Source files
------------

// File: rtl/dff_arb_pkg.sv
// Shared types and helpers for the DFF write arbiter.
package dff_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SAMPLE = 1'b1
    } state_t;

    localparam int DEF_N = 4;
    localparam int DEF_W = 8;
    localparam int MAX_N = 8;

    // One-hot vector with bit idx set; callers narrow it to their own N.
    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
        logic [MAX_N-1:0] one;
        one = {{(MAX_N-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/dff_write_arbiter_if.sv
// Requester-side bus of the DFF write arbiter: requests and data in,
// acknowledge, grant status and shared register contents out.
interface dff_write_arbiter_if #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int PW = $clog2(N)
);
    logic [N-1:0]   REQ;
    logic [N*W-1:0] DIN;
    logic [N-1:0]   ACK;
    logic           GNT_VLD;
    logic [PW-1:0]  GNT_ID;
    logic [W-1:0]   Q;
    logic           BUSY;

    modport master (
        output REQ, DIN,
        input  ACK, GNT_VLD, GNT_ID, Q, BUSY
    );

    modport slave (
        input  REQ, DIN,
        output ACK, GNT_VLD, GNT_ID, Q, BUSY
    );
endinterface

// File: rtl/dff_arb_rr_pick.sv
// Round-robin picker: first set bit of e, searching from ptr upward and
// wrapping modulo N. Purely combinational.
module dff_arb_rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  e,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] winner,
    output logic          any
);

    // Scan N positions starting at ptr; the first eligible one wins.
    always_comb begin
        int idx;
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!any && e[idx]) begin
                any    = 1'b1;
                winner = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/dff_write_arbiter.sv
// Round-robin write arbiter in front of one shared W-bit register.
// A requester is granted in IDLE, its data is captured on the following
// (SAMPLE) edge and ACK pulses in the cycle Q shows the new value.
// Optional build macro DFF_ARB_PRIO0_EN: requester 0 wins whenever it is
// eligible, and grants to 0 leave the round-robin pointer where it was.
module dff_write_arbiter
    import dff_arb_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int W  = DEF_W,
    parameter int PW = $clog2(N)
) (
    input  logic                CK,
    input  logic                RST,
    dff_write_arbiter_if.slave  bus
);

    state_t         state;
    logic [PW-1:0]  ptr;
    logic [W-1:0]   q_r;
    logic [N-1:0]   ack_r;
    logic           gnt_vld_r;
    logic [PW-1:0]  gnt_id_r;
    logic           busy_r;

    logic [N-1:0]   elig;
    logic [PW-1:0]  rr_win;
    logic           rr_any;
    logic [PW-1:0]  win;
    logic [N-1:0]   gnt_hot;
    logic [PW-1:0]  ptr_next;
    logic           keep_ptr;

    // The requester acked last cycle sits out one arbitration round.
    assign elig = bus.REQ & ~ack_r;

    dff_arb_rr_pick #(.N(N), .PW(PW)) u_pick (
        .e      (elig),
        .ptr    (ptr),
        .winner (rr_win),
        .any    (rr_any)
    );

`ifdef DFF_ARB_PRIO0_EN
    assign win      = elig[0] ? '0 : rr_win;
    assign keep_ptr = (gnt_id_r == '0);
`else
    assign win      = rr_win;
    assign keep_ptr = 1'b0;
`endif

    assign gnt_hot  = N'(onehot(32'(gnt_id_r)));
    assign ptr_next = (gnt_id_r == PW'(N - 1)) ? '0 : gnt_id_r + 1'b1;

    // Two-state grant/sample sequencer with all outputs registered.
    always_ff @(posedge CK) begin
        if (RST) begin
            state     <= IDLE;
            ptr       <= '0;
            q_r       <= '0;
            ack_r     <= '0;
            gnt_vld_r <= 1'b0;
            gnt_id_r  <= '0;
            busy_r    <= 1'b0;
        end else begin
            ack_r <= '0;
            case (state)
                IDLE: begin
                    if (rr_any) begin
                        gnt_id_r  <= win;
                        gnt_vld_r <= 1'b1;
                        busy_r    <= 1'b1;
                        state     <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    gnt_vld_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state     <= IDLE;
                    // A requester that dropped REQ before this edge aborts:
                    // no write, no ACK, pointer untouched.
                    if (bus.REQ[gnt_id_r]) begin
                        q_r   <= bus.DIN[int'(gnt_id_r)*W +: W];
                        ack_r <= gnt_hot;
                        if (!keep_ptr) begin
                            ptr <= ptr_next;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_vld_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Q       = q_r;
    assign bus.ACK     = ack_r;
    assign bus.GNT_VLD = gnt_vld_r;
    assign bus.GNT_ID  = gnt_id_r;
    assign bus.BUSY    = busy_r;

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Bench for dff_write_arbiter: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// transaction-level model of the arbitration rules.
module tb_dff_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int PW = 2;

    logic ck  = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    dff_write_arbiter_if #(.N(N), .W(W)) ifc ();

    dff_write_arbiter #(.N(N), .W(W)) dut (
        .CK  (ck),
        .RST (rst),
        .bus (ifc)
    );

    always #5 ck = ~ck;

    // Reference model state
    logic [W-1:0] m_q    = '0;
    logic [N-1:0] m_ack  = '0;
    logic         m_vld  = 1'b0;
    int           m_id   = 0;
    logic         m_busy = 1'b0;
    int           m_ptr  = 0;
    logic         m_pend = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a grant is chosen from the eligible set, and on the next edge
    // the granted requester either writes (still requesting) or aborts.
    always @(posedge ck) begin
        logic [N-1:0] elig;
        int  win;
        bit  found;
        if (rst) begin
            m_q = '0; m_ack = '0; m_vld = 1'b0; m_id = 0;
            m_busy = 1'b0; m_ptr = 0; m_pend = 1'b0;
        end else if (!m_pend) begin
            elig  = ifc.REQ & ~m_ack;
            m_ack = '0;
            found = 1'b0;
            win   = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && elig[(m_ptr + k) % N]) begin
                    found = 1'b1;
                    win   = (m_ptr + k) % N;
                end
            end
`ifdef DFF_ARB_PRIO0_EN
            if (elig[0]) win = 0;
`endif
            if (found) begin
                m_id = win; m_vld = 1'b1; m_busy = 1'b1; m_pend = 1'b1;
            end
        end else begin
            m_ack = '0; m_vld = 1'b0; m_busy = 1'b0; m_pend = 1'b0;
            if (ifc.REQ[m_id]) begin
                m_q   = ifc.DIN[m_id*W +: W];
                m_ack = N'(1) << m_id;
`ifdef DFF_ARB_PRIO0_EN
                if (m_id != 0) m_ptr = (m_id + 1) % N;
`else
                m_ptr = (m_id + 1) % N;
`endif
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge ck) begin
        if (chk_en) begin
            check("q",       32'(ifc.Q),       32'(m_q));
            check("ack",     32'(ifc.ACK),     32'(m_ack));
            check("gnt_vld", 32'(ifc.GNT_VLD), 32'(m_vld));
            check("gnt_id",  32'(ifc.GNT_ID),  32'(m_id));
            check("busy",    32'(ifc.BUSY),    32'(m_busy));
            check("ack_onehot0", 32'($countones(ifc.ACK) <= 1), 32'd1);
        end
    end

    task automatic step();
        @(negedge ck);
    endtask

    task automatic set_din(input int i, input logic [W-1:0] v);
        ifc.DIN[i*W +: W] = v;
    endtask

    initial begin
        logic [N-1:0] r;
        ifc.REQ = '0;
        ifc.DIN = '0;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_q",    32'(ifc.Q),       32'h0);
        check("rst_ack",  32'(ifc.ACK),     32'h0);
        check("rst_vld",  32'(ifc.GNT_VLD), 32'h0);
        check("rst_id",   32'(ifc.GNT_ID),  32'h0);
        check("rst_busy", 32'(ifc.BUSY),    32'h0);

`ifndef DFF_ARB_PRIO0_EN
        // Single requester 2
        ifc.REQ = 4'b0100; set_din(2, 8'hA5);
        step();
        check("single_id",  32'(ifc.GNT_ID),  32'd2);
        check("single_vld", 32'(ifc.GNT_VLD), 32'd1);
        check("single_busy", 32'(ifc.BUSY),   32'd1);
        step();
        check("single_q",   32'(ifc.Q),   32'hA5);
        check("single_ack", 32'(ifc.ACK), 32'b0100);
        ifc.REQ = '0;
        step();
        check("single_ack_clr", 32'(ifc.ACK), 32'h0);

        // Wrap: pointer at 3, requesters 3 and 0
        ifc.REQ = 4'b1001; set_din(3, 8'h33); set_din(0, 8'hC0);
        step();
        check("wrap_id3", 32'(ifc.GNT_ID), 32'd3);
        step();
        check("wrap_q3",   32'(ifc.Q),   32'h33);
        check("wrap_ack3", 32'(ifc.ACK), 32'b1000);
        ifc.REQ = 4'b0001;
        step();
        check("wrap_id0", 32'(ifc.GNT_ID), 32'd0);
        step();
        check("wrap_q0",   32'(ifc.Q),   32'hC0);
        check("wrap_ack0", 32'(ifc.ACK), 32'b0001);
        ifc.REQ = '0;
        step();

        // Abort by requester 2 (pointer at 1); pointer must stay at 1
        ifc.REQ = 4'b0100;
        step();
        check("abort_id", 32'(ifc.GNT_ID), 32'd2);
        ifc.REQ = '0;
        step();
        check("abort_q",    32'(ifc.Q),       32'hC0);
        check("abort_ack",  32'(ifc.ACK),     32'h0);
        check("abort_vld",  32'(ifc.GNT_VLD), 32'h0);
        check("abort_busy", 32'(ifc.BUSY),    32'h0);
        ifc.REQ = 4'b1111; set_din(1, 8'h5A);
        step();
        check("abort_ptr_kept", 32'(ifc.GNT_ID), 32'd1);
        step();
        check("abort_next_q", 32'(ifc.Q), 32'h5A);
        ifc.REQ = '0;
        step();

        // Reset in the middle of a SAMPLE cycle
        ifc.REQ = 4'b0010; set_din(1, 8'h77);
        step();
        check("midrst_pre_vld", 32'(ifc.GNT_VLD), 32'd1);
        rst = 1'b1;
        step(); step();
        check("midrst_q",    32'(ifc.Q),       32'h0);
        check("midrst_ack",  32'(ifc.ACK),     32'h0);
        check("midrst_vld",  32'(ifc.GNT_VLD), 32'h0);
        check("midrst_busy", 32'(ifc.BUSY),    32'h0);
        rst = 1'b0;
        step();
        check("midrst_regrant", 32'(ifc.GNT_ID), 32'd1);
        step();
        check("midrst_q1",   32'(ifc.Q),   32'h77);
        check("midrst_ack1", 32'(ifc.ACK), 32'b0010);
        ifc.REQ = '0;
        step();

        // Full contention from a fresh pointer
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_din(i, 8'(8'h10 + i));
        ifc.REQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            check("cont_id", 32'(ifc.GNT_ID), 32'(k % N));
            step();
            check("cont_q",   32'(ifc.Q),   32'(8'h10 + (k % N)));
            check("cont_ack", 32'(ifc.ACK), 32'(1 << (k % N)));
        end
        ifc.REQ = '0;
        step(); step();
`else
        // Requester 0 overrides the pointer
        ifc.REQ = 4'b1110;
        for (int i = 0; i < N; i++) set_din(i, 8'(8'h20 + i));
        step();
        check("prio_first_id", 32'(ifc.GNT_ID), 32'd1);
        step();
        check("prio_first_q", 32'(ifc.Q), 32'h21);
        ifc.REQ = 4'b1111;
        step();
        check("prio_zero_wins", 32'(ifc.GNT_ID), 32'd0);
        step();
        check("prio_zero_q",   32'(ifc.Q),   32'h20);
        check("prio_zero_ack", 32'(ifc.ACK), 32'b0001);
        ifc.REQ = 4'b1110;
        step();
        check("prio_ptr_kept", 32'(ifc.GNT_ID), 32'd2);
        ifc.REQ = '0;
        step(); step();
`endif

        // Randomized traffic, requests mostly held across cycles
        r = '0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            ifc.REQ = r;
            ifc.DIN = 32'($urandom);
            step();
        end
        ifc.REQ = '0;
        rst = 1'b0;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
